// File: rtl/map_writer.sv
// Tile-map store for a 20x15 playfield: raster initialisation of the wall grid,
// WRITE/DESTROY command handling, and a never-stalling renderer read port.
module map_writer #(
  parameter int unsigned COLS         = 20,
  parameter int unsigned ROWS         = 15,
  parameter int unsigned WALL_SPRITE  = 1,
  parameter int unsigned BRICK_SPRITE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [4:0] cmd_col,
  input  logic [3:0] cmd_row,
  input  logic [3:0] cmd_sprite,
  input  logic [4:0] rd_col,
  input  logic [3:0] rd_row,
  output logic [3:0] rd_sprite,
  output logic       init_done,
  output logic       destroyed,
  output logic       cmd_err
);

  localparam int unsigned CW    = 5;
  localparam int unsigned RW    = 4;
  localparam int unsigned SW    = 4;
  localparam int unsigned AW    = RW + CW;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ic_col_q, ic_col_d;
  logic [RW-1:0] ic_row_q, ic_row_d;
  logic          op_q, op_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] spr_q, spr_d;
  logic [SW-1:0] rdv_q;
  logic          init_done_q, init_done_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          destroyed_q, destroyed_d;
  logic          cmd_err_q, cmd_err_d;
  logic [SW-1:0] rd_sprite_q;

  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [SW-1:0] mem_wdata_c;
  logic          rd_in_range_c;

  logic [SW-1:0] mem [DEPTH];

  // Border cells and every even/even cell are indestructible walls.
  function automatic logic [SW-1:0] init_value(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic wall;
    wall = (r == RW'(0)) || (r == RW'(ROWS - 1)) ||
           (c == CW'(0)) || (c == CW'(COLS - 1)) ||
           (!r[0] && !c[0]);
    return wall ? SW'(WALL_SPRITE) : SW'(0);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      ic_col_q    <= '0;
      ic_row_q    <= '0;
      op_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      spr_q       <= '0;
      init_done_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      destroyed_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ic_col_q    <= ic_col_d;
      ic_row_q    <= ic_row_d;
      op_q        <= op_d;
      col_q       <= col_d;
      row_q       <= row_d;
      spr_q       <= spr_d;
      init_done_q <= init_done_d;
      cmd_ready_q <= cmd_ready_d;
      destroyed_q <= destroyed_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ic_col_d    = ic_col_q;
    ic_row_d    = ic_row_q;
    op_d        = op_q;
    col_d       = col_q;
    row_d       = row_q;
    spr_d       = spr_q;
    init_done_d = init_done_q;
    cmd_ready_d = 1'b0;
    destroyed_d = 1'b0;
    cmd_err_d   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = {ic_row_q, ic_col_q};
    mem_wdata_c = init_value(ic_row_q, ic_col_q);

    case (state_q)
      S_INIT: begin
        // Row counter reaching ROWS marks the cycle after the last cell write.
        if (ic_row_q == RW'(ROWS)) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          mem_we_c = 1'b1;
          if (ic_col_q == CW'(COLS - 1)) begin
            ic_col_d = '0;
            ic_row_d = ic_row_q + RW'(1);
          end else begin
            ic_col_d = ic_col_q + CW'(1);
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          col_d = cmd_col;
          row_d = cmd_row;
          spr_d = cmd_sprite;
          if ((cmd_col >= CW'(COLS)) || (cmd_row >= RW'(ROWS))) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d = cmd_op ? S_RD : S_WR;
          end
        end
      end
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        mem_addr_c = {row_q, col_q};
        if (!op_q) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = spr_q;
        end else if (rdv_q == SW'(BRICK_SPRITE)) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = '0;
          destroyed_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Restart overrides everything, including a command accepted on this edge.
    if (restart) begin
      state_d     = S_INIT;
      ic_col_d    = '0;
      ic_row_d    = '0;
      init_done_d = 1'b0;
      destroyed_d = 1'b0;
      cmd_err_d   = 1'b0;
      mem_we_c    = 1'b0;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  // Map RAM: write port plus the internal read used by DESTROY.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
    if (state_q == S_RD) begin
      rdv_q <= mem[{row_q, col_q}];
    end
  end

  assign rd_in_range_c = (rd_col < CW'(COLS)) && (rd_row < RW'(ROWS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sprite_q <= '0;
    end else begin
      rd_sprite_q <= rd_in_range_c ? mem[{rd_row, rd_col}] : SW'(0);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;
  assign destroyed = destroyed_q;
  assign cmd_err   = cmd_err_q;
  assign rd_sprite = rd_sprite_q;

endmodule

// File: tb/tb_map_writer.sv
// Scoreboard bench for map_writer: stimulus queues expected reads and pulses,
// a monitor pops and compares them as the DUT presents them.
module tb_map_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [4:0] cmd_col;
  logic [3:0] cmd_row;
  logic [3:0] cmd_sprite;
  logic [4:0] rd_col;
  logic [3:0] rd_row;
  logic [3:0] rd_sprite;
  logic       init_done;
  logic       destroyed;
  logic       cmd_err;

  int         tests = 0;
  int         fails = 0;
  logic       rd_strobe = 1'b0;
  logic [3:0] rd_exp_q[$];
  string      rd_name_q[$];
  int         ev_q[$];   // 1 = destroyed pulse, 2 = cmd_err pulse

  map_writer dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_col   (cmd_col),
    .cmd_row   (cmd_row),
    .cmd_sprite(cmd_sprite),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_sprite (rd_sprite),
    .init_done (init_done),
    .destroyed (destroyed),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares renderer reads and output pulses against queued expectations.
  initial begin
    logic       s;
    logic [3:0] e;
    string      n;
    logic [31:0] code;
    forever begin
      @(posedge clk);
      s = rd_strobe;
      #1;
      if (s) begin
        if (rd_exp_q.size() == 0) begin
          chk("rd_unexpected", 32'(rd_sprite), 32'hFFFF_FFFF);
        end else begin
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          chk(n, 32'(rd_sprite), 32'(e));
        end
      end
      if (destroyed || cmd_err) begin
        code = {30'd0, cmd_err, destroyed};
        if (ev_q.size() == 0) chk("unexpected_pulse", code, 32'd0);
        else                  chk("pulse", code, 32'(ev_q.pop_front()));
      end
    end
  end

  task automatic rd(input logic [3:0] r, input logic [4:0] c, input logic [3:0] e, input string nm);
    @(negedge clk);
    rd_row    = r;
    rd_col    = c;
    rd_strobe = 1'b1;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic wait_init(input string nm, input int exp_edges);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) done = 1'b1;
    end
    chk(nm, 32'(n), 32'(exp_edges));
  endtask

  // ev: 0 = no pulse expected, 1 = destroyed, 2 = cmd_err (command rejected).
  task automatic cmd(input logic op, input logic [3:0] r, input logic [4:0] c,
                     input logic [3:0] s, input int ev, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_row    = r;
    cmd_col    = c;
    cmd_sprite = s;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_accept"}, 32'(cmd_ready), 32'd1);
    if (ev != 0) ev_q.push_back(ev);
    @(posedge clk);
    #1;
    if (ev == 2) chk({nm, "_ready_stays"}, 32'(cmd_ready), 32'd1);
    else         chk({nm, "_ready_low"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = ~op;
    cmd_row    = r + 4'd1;
    cmd_col    = c + 5'd1;
    cmd_sprite = s + 4'd3;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_pattern(input string p);
    rd(4'd0,  5'd5,  4'd1, {p, "_r0c5"});
    rd(4'd2,  5'd2,  4'd1, {p, "_r2c2"});
    rd(4'd1,  5'd1,  4'd0, {p, "_r1c1"});
    rd(4'd14, 5'd19, 4'd1, {p, "_r14c19"});
    rd(4'd3,  5'd4,  4'd0, {p, "_r3c4"});
  endtask

  initial begin
    reset      = 1'b1;
    restart    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_col    = 5'd0;
    cmd_row    = 4'd0;
    cmd_sprite = 4'd0;
    rd_col     = 5'd0;
    rd_row     = 4'd0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_destroyed", 32'(destroyed), 32'd0);
    chk("rst_cmd_err",   32'(cmd_err),   32'd0);
    chk("rst_rd_sprite", 32'(rd_sprite), 32'd0);
    reset = 1'b0;

    wait_init("init_edges", 301);
    chk("init_ready", 32'(cmd_ready), 32'd1);
    check_pattern("init");
    rd(4'd4,  5'd6,  4'd1, "init_r4c6");
    rd(4'd13, 5'd18, 4'd0, "init_r13c18");
    rd(4'd15, 5'd0,  4'd0, "oor_read_row");
    rd(4'd0,  5'd20, 4'd0, "oor_read_col");

    // WRITE, then DESTROY of a brick and of a wall.
    cmd(1'b0, 4'd3, 5'd5, 4'd2, 0, "wr_r3c5");
    rd(4'd3, 5'd5, 4'd2, "after_wr_r3c5");
    cmd(1'b1, 4'd3, 5'd5, 4'd0, 1, "destroy_brick");
    rd(4'd3, 5'd5, 4'd0, "after_destroy_r3c5");
    cmd(1'b1, 4'd2, 5'd2, 4'd0, 0, "destroy_wall");
    rd(4'd2, 5'd2, 4'd1, "after_destroy_r2c2");

    // Captured fields: inputs scrambled after acceptance must not matter.
    cmd(1'b0, 4'd6, 5'd7, 4'd9, 0, "wr_r6c7");
    rd(4'd6, 5'd7, 4'd9, "capture_r6c7");
    rd(4'd7, 5'd8, 4'd0, "capture_r7c8");

    // Out-of-range commands.
    cmd(1'b0, 4'd15, 5'd3,  4'd2, 2, "oor_row");
    cmd(1'b0, 4'd4,  5'd20, 4'd2, 2, "oor_col");
    rd(4'd14, 5'd3,  4'd1, "oor_r14c3");
    rd(4'd4,  5'd19, 4'd1, "oor_r4c19");

    // Restart on the accept edge of a WRITE to (1,1).
    @(negedge clk);
    chk("restart_pre_ready", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_op     = 1'b0;
    cmd_row    = 4'd1;
    cmd_col    = 5'd1;
    cmd_sprite = 4'd5;
    restart    = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_init_done_low", 32'(init_done), 32'd0);
    chk("restart_ready_low",     32'(cmd_ready), 32'd0);
    @(negedge clk);
    restart   = 1'b0;
    cmd_valid = 1'b0;
    wait_init("reinit_edges", 301);
    rd(4'd1, 5'd1, 4'd0, "reinit_r1c1");
    rd(4'd6, 5'd7, 4'd0, "reinit_r6c7");

    // Reset asserted with the init counter at cell 150.
    cmd(1'b0, 4'd13, 5'd17, 4'd7, 0, "wr_r13c17");
    rd(4'd13, 5'd17, 4'd7, "pre_reset_r13c17");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midinit_rst_init_done", 32'(init_done), 32'd0);
    chk("midinit_rst_rd_sprite", 32'(rd_sprite), 32'd0);
    reset = 1'b0;
    wait_init("midinit_reinit_edges", 301);
    check_pattern("midinit");
    rd(4'd13, 5'd17, 4'd0, "midinit_r13c17");
    rd(4'd7,  5'd10, 4'd0, "midinit_r7c10");
    rd(4'd8,  5'd10, 4'd1, "midinit_r8c10");

    repeat (5) @(negedge clk);
    chk("rd_queue_drained",    32'(rd_exp_q.size()), 32'd0);
    chk("event_queue_drained", 32'(ev_q.size()),     32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/map_writer.md
MAP_WRITER -- requirements
Module: map_writer

Interface
REQ-001 Parameters: COLS, 20, tile columns (32-px tiles, 640 px); ROWS, 15, tile rows (480 px); WALL_SPRITE, 1, indestructible wall sprite_num; BRICK_SPRITE, 2, destructible brick sprite_num.
REQ-002 clk  input  1  single system clock, all logic on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 restart  input  1  one-cycle pulse; re-runs map initialisation.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-007 cmd_op  input  1  0 = WRITE tile, 1 = DESTROY tile.
REQ-008 cmd_col  input  5  target column; cmd_row input 4 target row; cmd_sprite input 4 sprite_num for WRITE.
REQ-009 rd_col  input  5  renderer read column; rd_row input 4 renderer read row.
REQ-010 rd_sprite  output  4  sprite_num of tile (rd_row, rd_col), one-cycle latency.
REQ-011 init_done  output  1  high while map is valid (init complete).
REQ-012 destroyed  output  1  one-cycle pulse: DESTROY removed a brick.
REQ-013 cmd_err  output  1  one-cycle pulse: accepted command had out-of-range coordinates.

Function
REQ-014 Map storage SHALL be 512x4 RAM, address {row[3:0], col[4:0]}, one write port plus one renderer read port and one internal read port.
REQ-015 rd_sprite SHALL equal map[{rd_row, rd_col}] sampled at the previous edge; out-of-range read coordinates SHALL return 0.
REQ-016 FSM states SHALL be INIT, IDLE, RD, WR.
REQ-017 INIT SHALL walk all COLS*ROWS cells in raster order (col fastest), one write per cycle, total 300 cycles, then go to IDLE.
REQ-018 INIT value: WALL_SPRITE if row==0, row==ROWS-1, col==0, col==COLS-1, or (row even and col even); else 0.
REQ-019 init_done SHALL rise the cycle after the last INIT write and stay high until reset or restart.
REQ-020 cmd_ready SHALL be high only in IDLE; low in INIT, RD, WR.
REQ-021 Accepted WRITE in range: IDLE->WR; WR writes cmd_sprite at the captured address; WR->IDLE; one command per 2 cycles max.
REQ-022 Accepted DESTROY in range: IDLE->RD (internal read of captured address) ->WR; in WR, if value==BRICK_SPRITE, write 0 and pulse destroyed; else no write, no pulse; WR->IDLE.
REQ-023 Accepted command with col>=COLS or row>=ROWS SHALL pulse cmd_err the following cycle, perform no write, and stay in IDLE.
REQ-024 Command fields SHALL be captured on acceptance; later input changes have no effect.
REQ-025 restart in any state SHALL abort any pending command without writing, clear init_done, reset the init counter, and enter INIT next cycle.
REQ-026 restart and command acceptance on the same edge: restart wins; the command is dropped.
REQ-027 Renderer reads SHALL never stall and SHALL observe a write one cycle after the write edge.

Reset
REQ-028 On reset: state=INIT, init counter=0, cmd_ready=0, init_done=0, destroyed=0, cmd_err=0, rd_sprite=0; RAM contents undefined until INIT completes.
REQ-029 Reset asserted mid-INIT or mid-command SHALL restart INIT from cell (0,0) after deassertion.

Verification
REQ-030 Release reset, wait -> init_done rises exactly 301 cycles after the first edge; (0,5)=1, (2,2)=1, (1,1)=0, (14,19)=1, (3,4)=0.
REQ-031 After init: WRITE (row 3, col 5, sprite 2), then read (3,5) -> rd_sprite=2; cmd_ready low one cycle after accept.
REQ-032 DESTROY (3,5) holding 2 -> destroyed pulses once, (3,5) reads 0; DESTROY (2,2) holding 1 -> no pulse, (2,2) stays 1.
REQ-033 WRITE (row 15, col 3) and (row 4, col 20) -> cmd_err pulses each, no map change, cmd_ready stays high.
REQ-034 restart on the accept edge of a WRITE to (1,1) sprite 5 -> no write, init_done falls, re-init completes, (1,1)=0.
REQ-035 Reset asserted at init cell 150 -> after release, full 300-cycle init with correct pattern.
